// File: rtl/neo_pattern_gen.sv
// Addressable-LED frame pattern generator: walks pixels/channels, hands levels to a serial driver.
// Optional NEO_GAMMA_EN macro squares each level (gamma ~2) before it is emitted.
module neo_pattern_gen #(
    parameter int unsigned NUM_PIXELS = 5,
    parameter int unsigned LEVEL_W    = 8,
    parameter int unsigned STEP       = 8,
    parameter int unsigned SPACING    = 32,
    localparam int unsigned PIX_W     = (NUM_PIXELS > 1) ? $clog2(NUM_PIXELS) : 1
) (
    input  logic               clock,
    input  logic               reset_n,
    input  logic               enable,
    input  logic [1:0]         mode,
    input  logic               ready_to_load,
    input  logic               ready_to_send,
    output logic [PIX_W-1:0]   pixel_index,
    output logic [1:0]         color_index,
    output logic [LEVEL_W-1:0] color_level,
    output logic               load_it,
    output logic               send_it,
    output logic               frame_done,
    output logic [15:0]        frame_count
);

    localparam logic [1:0] MODE_SOLID   = 2'd0;
    localparam logic [1:0] MODE_RAINBOW = 2'd1;
    localparam logic [1:0] MODE_CHASE   = 2'd2;

    localparam logic [PIX_W-1:0]   PIX_LAST  = PIX_W'(NUM_PIXELS - 1);
    localparam logic [LEVEL_W-1:0] STEP_L    = LEVEL_W'(STEP);
    localparam logic [LEVEL_W-1:0] SPACING_L = LEVEL_W'(SPACING);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_SEND = 2'd2,
        ST_WAIT = 2'd3
    } state_t;

    state_t             state, state_nxt;
    logic [PIX_W-1:0]   pix_cnt, pix_nxt;
    logic [1:0]         col_cnt, col_nxt;
    logic [LEVEL_W-1:0] phase, phase_nxt;
    logic [PIX_W-1:0]   chase_pos, chase_nxt;
    logic [1:0]         mode_r, mode_nxt;
    logic [15:0]        fcount_nxt;

    logic [1:0]         rb_chan;
    logic [LEVEL_W-1:0] rb_level;
    logic [LEVEL_W-1:0] lin_level;
    logic [LEVEL_W-1:0] out_level;

    // State and frame-context registers
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state       <= ST_IDLE;
            pix_cnt     <= '0;
            col_cnt     <= '0;
            phase       <= '0;
            chase_pos   <= '0;
            mode_r      <= '0;
            frame_count <= '0;
        end else begin
            state       <= state_nxt;
            pix_cnt     <= pix_nxt;
            col_cnt     <= col_nxt;
            phase       <= phase_nxt;
            chase_pos   <= chase_nxt;
            mode_r      <= mode_nxt;
            frame_count <= fcount_nxt;
        end
    end

    // Next-state and strobes
    always_comb begin
        state_nxt  = state;
        pix_nxt    = pix_cnt;
        col_nxt    = col_cnt;
        phase_nxt  = phase;
        chase_nxt  = chase_pos;
        mode_nxt   = mode_r;
        fcount_nxt = frame_count;
        load_it    = 1'b0;
        send_it    = 1'b0;
        frame_done = 1'b0;

        case (state)
            ST_IDLE: begin
                if (enable) begin
                    state_nxt = ST_LOAD;
                    mode_nxt  = mode;
                    pix_nxt   = '0;
                    col_nxt   = '0;
                end
            end
            ST_LOAD: begin
                load_it = ready_to_load;
                if (ready_to_load) begin
                    if (col_cnt == 2'd2) begin
                        col_nxt = 2'd0;
                        if (pix_cnt == PIX_LAST) begin
                            pix_nxt   = '0;
                            state_nxt = ST_SEND;
                        end else begin
                            pix_nxt = pix_cnt + PIX_W'(1);
                        end
                    end else begin
                        col_nxt = col_cnt + 2'd1;
                    end
                end
            end
            ST_SEND: begin
                send_it   = ready_to_send;
                state_nxt = ST_WAIT;
            end
            ST_WAIT: begin
                // Driver is ready again: the frame is finished, move the animation on
                if (ready_to_load) begin
                    frame_done = 1'b1;
                    fcount_nxt = frame_count + 16'd1;
                    phase_nxt  = phase + STEP_L;
                    chase_nxt  = (chase_pos == PIX_LAST) ? '0 : chase_pos + PIX_W'(1);
                    pix_nxt    = '0;
                    col_nxt    = '0;
                    if (enable) begin
                        state_nxt = ST_LOAD;
                        mode_nxt  = mode;
                    end else begin
                        state_nxt = ST_IDLE;
                    end
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    assign rb_chan  = 2'(32'(pix_cnt) % 32'd3);
    assign rb_level = phase + LEVEL_W'(pix_cnt) * SPACING_L;

    // Linear level for the current pixel/channel
    always_comb begin
        lin_level = '0;
        case (mode_r)
            MODE_SOLID:   if (col_cnt == 2'd1)        lin_level = phase;
            MODE_RAINBOW: if (col_cnt == rb_chan)     lin_level = rb_level;
            MODE_CHASE:   if (pix_cnt == chase_pos)   lin_level = '1;
            default:      lin_level = '0;
        endcase
    end

`ifdef NEO_GAMMA_EN
    logic [2*LEVEL_W-1:0] lin_sq;
    assign lin_sq    = (2*LEVEL_W)'(lin_level) * (2*LEVEL_W)'(lin_level);
    assign out_level = LEVEL_W'(lin_sq >> LEVEL_W);
`else
    assign out_level = lin_level;
`endif

    assign pixel_index = (state == ST_LOAD) ? pix_cnt   : '0;
    assign color_index = (state == ST_LOAD) ? col_cnt   : 2'd0;
    assign color_level = (state == ST_LOAD) ? out_level : '0;

endmodule

// File: tb/tb_neo_pattern_gen.sv
// Randomized bench for neo_pattern_gen against a frame-level reference model.
// Honours NEO_GAMMA_EN the same way as the design.
module tb_neo_pattern_gen;

    localparam int unsigned NUM_PIXELS = 5;
    localparam int unsigned LEVEL_W    = 8;
    localparam int unsigned STEP       = 8;
    localparam int unsigned SPACING    = 32;
    localparam int unsigned PIX_W      = 3;
    localparam int          LMAX       = 1 << LEVEL_W;

    logic               clock;
    logic               reset_n;
    logic               enable;
    logic [1:0]         mode;
    logic               ready_to_load;
    logic               ready_to_send;
    logic [PIX_W-1:0]   pixel_index;
    logic [1:0]         color_index;
    logic [LEVEL_W-1:0] color_level;
    logic               load_it;
    logic               send_it;
    logic               frame_done;
    logic [15:0]        frame_count;

    int tests_run    = 0;
    int tests_failed = 0;

    neo_pattern_gen #(
        .NUM_PIXELS (NUM_PIXELS),
        .LEVEL_W    (LEVEL_W),
        .STEP       (STEP),
        .SPACING    (SPACING)
    ) dut (
        .clock         (clock),
        .reset_n       (reset_n),
        .enable        (enable),
        .mode          (mode),
        .ready_to_load (ready_to_load),
        .ready_to_send (ready_to_send),
        .pixel_index   (pixel_index),
        .color_index   (color_index),
        .color_level   (color_level),
        .load_it       (load_it),
        .send_it       (send_it),
        .frame_done    (frame_done),
        .frame_count   (frame_count)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    // Level the pattern rules give for frame number f (frames completed since reset)
    function automatic int exp_level(input int md, input int pix, input int col, input int f);
        int ph, l;
        ph = (f * STEP) % LMAX;
        l  = 0;
        case (md)
            0: l = (col == 1) ? ph : 0;
            1: l = (col == pix % 3) ? (ph + pix * SPACING) % LMAX : 0;
            2: l = (pix == f % NUM_PIXELS) ? LMAX - 1 : 0;
            default: l = 0;
        endcase
`ifdef NEO_GAMMA_EN
        l = (l * l) >> LEVEL_W;
`endif
        return l;
    endfunction

    // Reference model: 0 idle, 1 loading, 2 send slot, 3 waiting for driver
    int m_st = 0, m_k = 0, m_mode = 0, m_f = 0;

    always @(negedge clock) begin
        int e_pix, e_col, e_lvl, e_load, e_send, e_done;
        e_pix = 0; e_col = 0; e_lvl = 0; e_load = 0; e_send = 0; e_done = 0;
        if (!reset_n) begin
            m_st = 0; m_k = 0; m_mode = 0; m_f = 0;
        end else begin
            case (m_st)
                1: begin
                    e_pix  = m_k / 3;
                    e_col  = m_k % 3;
                    e_lvl  = exp_level(m_mode, e_pix, e_col, m_f);
                    e_load = int'(ready_to_load);
                end
                2: e_send = int'(ready_to_send);
                3: e_done = int'(ready_to_load);
                default: ;
            endcase
        end
        check("pixel_index", 32'(pixel_index), 32'(e_pix));
        check("color_index", 32'(color_index), 32'(e_col));
        check("color_level", 32'(color_level), 32'(e_lvl));
        check("load_it",     32'(load_it),     32'(e_load));
        check("send_it",     32'(send_it),     32'(e_send));
        check("frame_done",  32'(frame_done),  32'(e_done));
        check("frame_count", 32'(frame_count), 32'(m_f % 65536));
        if (reset_n) begin
            case (m_st)
                0: if (enable) begin m_st = 1; m_k = 0; m_mode = int'(mode); end
                1: if (ready_to_load) begin
                       m_k++;
                       if (m_k == 3 * NUM_PIXELS) m_st = 2;
                   end
                2: m_st = 3;
                3: if (ready_to_load) begin
                       m_f++;
                       if (enable) begin m_st = 1; m_k = 0; m_mode = int'(mode); end
                       else m_st = 0;
                   end
                default: m_st = 0;
            endcase
        end
    end

    task automatic run_steady(input logic [1:0] md, input int cycles);
        mode = md; enable = 1'b1; ready_to_load = 1'b1; ready_to_send = 1'b1;
        repeat (cycles) @(posedge clock);
        #1;
    endtask

    initial begin
        reset_n = 1'b0; enable = 1'b0; mode = 2'd0;
        ready_to_load = 1'b0; ready_to_send = 1'b0;
        repeat (3) @(posedge clock);
        #1 reset_n = 1'b1;

        run_steady(2'd0, 40);
        run_steady(2'd1, 40);
        run_steady(2'd2, 110);
        enable = 1'b0;
        repeat (40) @(posedge clock);
        #1;

        // Reset mid-frame after seven loads
        run_steady(2'd0, 8);
        reset_n = 1'b0;
        #1;
        check("rst_load_it",     32'(load_it),     32'd0);
        check("rst_pixel_index", 32'(pixel_index), 32'd0);
        check("rst_color_index", 32'(color_index), 32'd0);
        check("rst_frame_count", 32'(frame_count), 32'd0);
        repeat (2) @(posedge clock);
        #1 reset_n = 1'b1;
        run_steady(2'd0, 300);

        // Randomized handshakes, mid-frame mode/enable changes, occasional reset
        for (int i = 0; i < 4000; i++) begin
            ready_to_load = ($urandom_range(0, 3) != 0);
            ready_to_send = $urandom_range(0, 1) != 0;
            if ($urandom_range(0, 19) == 0) mode = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 29) == 0) enable = ~enable;
            if ($urandom_range(0, 799) == 0) begin
                reset_n = 1'b0;
                #1;
                check("rst_async_load", 32'(load_it), 32'd0);
                check("rst_async_level", 32'(color_level), 32'd0);
                @(posedge clock);
                #1 reset_n = 1'b1;
            end
            @(posedge clock);
            #1;
        end

        @(negedge clock);
        #1;
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
